pulse_frame_tx: RTL and testbench

Transmit-side counterpart of the receive synchronizer. It keys a pulse train onto the RF link.
- A frame is PREAMBLE_SIZE unconditional pulses at a fixed slot interval, followed by PACKET_SIZE on-off-keyed data slots.
- Each data slot carries a pulse for a '1' bit and stays silent for a '0' bit, MSB first.
- The far-end synchronizer averages the preamble spacing and then strobes its sample-and-hold mid-slot.
- The block sits between the TX payload source and the RF driver.

---
 rtl/pulse_frame_tx.sv | 105 ++++++++++
 tb/tb_pulse_frame_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_frame_tx.sv
// Pulse-train frame transmitter: PREAMBLE_SIZE unconditional pulses, then PACKET_SIZE
// on-off-keyed data slots (MSB first), each slot PULSE_INTERVAL cycles long.
module pulse_frame_tx #(
  parameter int PREAMBLE_SIZE  = 8,
  parameter int PACKET_SIZE    = 64,
  parameter int PULSE_INTERVAL = 10000,
  parameter int PULSE_WIDTH    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [PACKET_SIZE-1:0] data_in,
  input  logic                   abort,
  output logic                   rf_out,
  output logic                   busy,
  output logic                   done,
  output logic [6:0]             slot_idx
);

  localparam int CW = (PULSE_INTERVAL > 1) ? $clog2(PULSE_INTERVAL) : 1;
  localparam logic [CW-1:0] CYC_LAST   = CW'(PULSE_INTERVAL - 1);
  localparam logic [CW-1:0] CYC_PW     = CW'(PULSE_WIDTH);
  localparam logic [6:0]    PRE_LAST   = 7'(PREAMBLE_SIZE - 1);
  localparam logic [6:0]    FRAME_LAST = 7'(PREAMBLE_SIZE + PACKET_SIZE - 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, FINISH} state_t;

  state_t                 state;
  logic [CW-1:0]          cyc_cnt;
  logic [6:0]             slot;
  logic [PACKET_SIZE-1:0] sr;
  logic                   start_q;

  // Outputs lag the slot/cycle counters by one clock, so slot k is visible from 1+k*PULSE_INTERVAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      slot     <= '0;
      sr       <= '0;
      // Seeded high so a start held across reset release needs a fresh low-to-high edge.
      start_q  <= 1'b1;
      rf_out   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      slot_idx <= '0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          rf_out   <= 1'b0;
          busy     <= 1'b0;
          slot_idx <= '0;
          if (start && !start_q && !abort) begin
            sr      <= data_in;
            cyc_cnt <= '0;
            slot    <= '0;
            state   <= PREAMBLE;
          end
        end
        PREAMBLE, DATA: begin
          if (abort) begin
            state    <= IDLE;
            rf_out   <= 1'b0;
            busy     <= 1'b0;
            slot_idx <= '0;
            slot     <= '0;
            cyc_cnt  <= '0;
          end else begin
            busy     <= 1'b1;
            slot_idx <= slot;
            rf_out   <= (cyc_cnt < CYC_PW) && (state == PREAMBLE || sr[PACKET_SIZE-1]);
            if (cyc_cnt == CYC_LAST) begin
              cyc_cnt <= '0;
              if (state == PREAMBLE) begin
                slot <= slot + 7'd1;
                if (slot == PRE_LAST) state <= DATA;
              end else begin
                sr <= sr << 1;
                if (slot == FRAME_LAST) begin
                  slot  <= '0;
                  state <= FINISH;
                end else begin
                  slot <= slot + 7'd1;
                end
              end
            end else begin
              cyc_cnt <= cyc_cnt + CW'(1);
            end
          end
        end
        FINISH: begin
          state    <= IDLE;
          rf_out   <= 1'b0;
          busy     <= 1'b0;
          slot_idx <= '0;
          done     <= !abort;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_frame_tx.sv
// Bench for pulse_frame_tx: time-based frame model compared every cycle, plus fixed scenarios.
module tb_pulse_frame_tx;

  localparam int PRE = 8;
  localparam int PKT = 8;
  localparam int PI  = 20;
  localparam int PW  = 3;
  localparam int NSL = PRE + PKT;

  logic           clk;
  logic           rst;
  logic           start;
  logic [PKT-1:0] data_in;
  logic           abort;
  logic           rf_out;
  logic           busy;
  logic           done;
  logic [6:0]     slot_idx;

  pulse_frame_tx #(
    .PREAMBLE_SIZE(PRE), .PACKET_SIZE(PKT), .PULSE_INTERVAL(PI), .PULSE_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .abort(abort),
    .rf_out(rf_out), .busy(busy), .done(done), .slot_idx(slot_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is described only by its acceptance cycle and latched payload.
  int       cyc_n = 0;
  bit       m_active = 0;
  bit       m_prev = 1;
  int       m_acc = 0;
  logic [PKT-1:0] m_data = '0;
  logic     e_rf = 0, e_busy = 0, e_done = 0;
  int       e_slot = 0;

  always @(posedge clk or posedge rst) begin
    int t, k, c;
    if (rst) begin
      m_active = 0; m_prev = 1;
      e_rf = 0; e_busy = 0; e_done = 0; e_slot = 0;
    end else begin
      cyc_n++;
      e_rf = 0; e_busy = 0; e_done = 0; e_slot = 0;
      if (m_active) begin
        t = cyc_n - m_acc;
        if (abort) begin
          m_active = 0;
        end else if (t <= NSL * PI) begin
          k = (t - 1) / PI;
          c = (t - 1) % PI;
          e_busy = 1;
          e_slot = k;
          e_rf = (c < PW) && (k < PRE || m_data[PKT-1-(k-PRE)] == 1'b1);
        end else begin
          e_done = 1;
          m_active = 0;
        end
      end else if (start && !m_prev && !abort) begin
        m_active = 1; m_acc = cyc_n; m_data = data_in;
      end
      m_prev = start;
    end
  end

  int    checks = 0, errors = 0;
  int    pulses_tot = 0, dones_tot = 0, last_done_cyc = -1;
  logic  rf_prev = 0;
  int    req_seq = 0, done_seq = 0;
  string req_name;
  int    req_act, req_exp;

  always @(negedge clk) begin
    checks++;
    if (rf_out !== e_rf || busy !== e_busy || done !== e_done || int'(slot_idx) != e_slot) begin
      errors++;
      if (errors < 30)
        $display("FAIL model cyc=%0d: rf/busy/done/slot got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 cyc_n, rf_out, busy, done, slot_idx, e_rf, e_busy, e_done, e_slot);
    end
    if (req_seq != done_seq) begin
      checks++;
      if (req_act != req_exp) begin
        errors++;
        $display("FAIL %s: got %0d want %0d", req_name, req_act, req_exp);
      end
      done_seq = req_seq;
    end
    if (rf_out && !rf_prev) pulses_tot++;
    rf_prev = rf_out;
    if (done) begin
      dones_tot++;
      last_done_cyc = cyc_n;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string n, input int act, input int exp);
    req_name = n; req_act = act; req_exp = exp;
    req_seq++;
    @(negedge clk);
    #1;
  endtask

  int p0, d0, acc1;

  task automatic frame(input logic [PKT-1:0] d);
    data_in = d;
    p0 = pulses_tot; d0 = dones_tot;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(330);
  endtask

  initial begin
    logic a_rf, a_busy, a_done;
    int   a_slot;
    rst = 1'b1; start = 1'b0; abort = 1'b0; data_in = '0;
    tick(3);
    chk("reset_rf", int'(rf_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_slot", int'(slot_idx), 0);
    rst = 1'b0;
    tick(2);

    // A5 frame: 8 preamble + 4 data pulses, done 321 cycles after acceptance
    frame(8'hA5);
    chk("a5_pulses", pulses_tot - p0, 12);
    chk("a5_dones", dones_tot - d0, 1);
    chk("a5_done_cycle", last_done_cyc - m_acc, 321);

    frame(8'h00);
    chk("x00_pulses", pulses_tot - p0, 8);
    frame(8'hFF);
    chk("xff_pulses", pulses_tot - p0, 16);

    // Restart attempt and payload change while a frame is in flight
    data_in = 8'hA5; p0 = pulses_tot; d0 = dones_tot;
    start = 1'b1; tick(1); start = 1'b0;
    tick(48); start = 1'b1; tick(1); start = 1'b0;
    tick(9); data_in = 8'h5A;
    tick(275);
    chk("busy_start_pulses", pulses_tot - p0, 12);
    chk("busy_start_dones", dones_tot - d0, 1);
    chk("busy_start_done_cycle", last_done_cyc - m_acc, 321);

    // Abort during data slot 8, then restart at 180
    data_in = 8'hA5; d0 = dones_tot;
    start = 1'b1; tick(1); start = 1'b0;
    acc1 = m_acc;
    tick(169); abort = 1'b1; tick(1); abort = 1'b0;
    a_rf = rf_out; a_busy = busy; a_slot = int'(slot_idx);
    chk("abort_rf", int'(a_rf), 0);
    chk("abort_busy", int'(a_busy), 0);
    chk("abort_slot", a_slot, 0);
    tick(6);
    start = 1'b1; tick(1); start = 1'b0;
    chk("abort_restart_at", m_acc - acc1, 180);
    tick(330);
    chk("abort_dones", dones_tot - d0, 1);
    chk("abort_restart_done", last_done_cyc - m_acc, 321);

    // Asynchronous reset between edges, with start held high through release
    data_in = 8'hA5;
    start = 1'b1; tick(1);
    tick(98);
    @(posedge clk); #3 rst = 1'b1;
    #1 a_rf = rf_out; a_busy = busy; a_done = done;
    @(negedge clk); rst = 1'b0;
    chk("arst_rf", int'(a_rf), 0);
    chk("arst_busy", int'(a_busy), 0);
    chk("arst_done", int'(a_done), 0);
    tick(30);
    chk("held_start_busy", int'(busy), 0);
    start = 1'b0; tick(1);
    frame(8'hA5);
    chk("after_rst_pulses", pulses_tot - p0, 12);
    chk("after_rst_dones", dones_tot - d0, 1);

    // Randomized starts, aborts and payload churn
    for (int f = 0; f < 15; f++) begin
      for (int c = 0; c < 340; c++) begin
        start   = ($urandom_range(0, 24) == 0);
        abort   = ($urandom_range(0, 499) == 0);
        data_in = PKT'($urandom);
        tick(1);
      end
    end
    start = 1'b0; abort = 1'b0;
    tick(340);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
